// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: M-extension funct3/funct7 codes and the muldiv FSM state encoding
package ex_muldiv_pkg;
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;
endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one radix-2 step; shift-add (mul) or restoring trial-subtract (div)
// div_i selects divide; p_i/p_o is the {hi,lo} working register; b_i is |multiplicand| or |divisor|.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] p_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] p_o
);
  logic [XLEN:0] sum, rem;
  logic [XLEN-1:0] dif;
  always_comb begin
    sum = {1'b0, p_i[2*XLEN-1:XLEN]} + (p_i[0] ? {1'b0, b_i} : '0);
    rem = p_i[2*XLEN-1:XLEN-1];
    dif = rem[XLEN-1:0] - b_i;
    p_o = div_i ? (rem >= {1'b0, b_i} ? {dif, p_i[XLEN-2:0], 1'b1} : {rem[XLEN-1:0], p_i[XLEN-2:0], 1'b0})
                : {sum, p_i[XLEN-1:1]};
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit; start_i/op_i/op1_i/op2_i/rd_addr_i in, flush_i aborts, busy_o stalls, done_o=rd_wen_o writes rd_data_o to rd_addr_o
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1,
  parameter int FAST_PATH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);
  localparam int ITER = XLEN / STEP_BITS;
  localparam int CW   = $clog2(ITER + 1);
  state_e state_q, state_d;
  logic [2:0] op_q;
  logic [XLEN-1:0] a_q, b_q, data_q, abs_a, abs_b, half, res;
  logic [4:0] rd_q, addr_q;
  logic [2*XLEN-1:0] p_q, p_neg;
  logic [CW-1:0] cnt_q;
  logic neg_q, neg_d, sgn1, sgn2, s1, s2, b_zero, ovf, fast;
  logic [2*XLEN-1:0] ch [STEP_BITS+1];
  assign ch[0] = p_q;
  for (genvar i = 0; i < STEP_BITS; i++) begin : g_step
    ex_muldiv_step #(.XLEN(XLEN)) u_step (.div_i(op_q[2]), .p_i(ch[i]), .b_i(b_q), .p_o(ch[i+1]));
  end
  always_comb begin
    sgn1   = !(op_q == INST_MULHU || op_q == INST_DIVU || op_q == INST_REMU);
    sgn2   = sgn1 && op_q != INST_MULHSU;
    s1     = sgn1 & a_q[XLEN-1];
    s2     = sgn2 & b_q[XLEN-1];
    abs_a  = s1 ? -a_q : a_q;
    abs_b  = s2 ? -b_q : b_q;
    b_zero = b_q == '0;
    ovf    = sgn2 && op_q[2] && a_q == {1'b1, {(XLEN-1){1'b0}}} && &b_q;
    fast   = FAST_PATH != 0 && op_q[2] && (b_zero || ovf);
    // divide by zero keeps a positive quotient so it stays all-ones; REM follows the dividend
    neg_d  = op_q[2] ? (op_q[1] ? s1 : (s1 ^ s2) & !b_zero) : s1 ^ s2;
    p_neg  = neg_q ? -p_q : p_q;
    half   = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
    res    = op_q[2] ? (neg_q ? -half : half)
                     : (op_q[1:0] == 2'b00 ? p_neg[XLEN-1:0] : p_neg[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? PREP : IDLE;
      PREP:    state_d = fast ? FIX : CALC;
      CALC:    state_d = cnt_q == CW'(1) ? FIX : CALC;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  assign done_o    = state_q == FIX && !flush_i;
  assign rd_wen_o  = done_o;
  assign rd_data_o = done_o ? res : data_q;
  assign rd_addr_o = done_o ? rd_q : addr_q;
  assign busy_o    = start_i | state_q == PREP | state_q == CALC;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        op_q <= op_i;
        a_q  <= op1_i;
        b_q  <= op2_i;
        rd_q <= rd_addr_i;
      end
      if (state_q == PREP) begin
        b_q   <= abs_b;
        neg_q <= neg_d;
        cnt_q <= CW'(ITER);
        // fast path preloads {remainder, quotient} so FIX selects the final answer directly
        p_q   <= fast && b_zero ? {abs_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, abs_a};
      end
      if (state_q == CALC) begin
        p_q   <= ch[STEP_BITS];
        cnt_q <= cnt_q - CW'(1);
      end
      if (done_o) begin
        data_q <= res;
        addr_q <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and model-checked vectors on radix-2 and radix-16 instances
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst, flush_i;
  logic [2:0] op_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0] rd_i;
  logic start [2];
  logic busy [2];
  logic done [2];
  logic wen [2];
  logic [4:0] ra [2];
  logic [31:0] rdat [2];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  ex_muldiv #(.XLEN(32), .STEP_BITS(1), .FAST_PATH(1)) u0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_i), .flush_i(flush_i), .busy_o(busy[0]), .done_o(done[0]),
    .rd_addr_o(ra[0]), .rd_data_o(rdat[0]), .rd_wen_o(wen[0]));
  ex_muldiv #(.XLEN(32), .STEP_BITS(4), .FAST_PATH(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_i), .flush_i(flush_i), .busy_o(busy[1]), .done_o(done[1]),
    .rd_addr_o(ra[1]), .rd_data_o(rdat[1]), .rd_wen_o(wen[1]));
  typedef struct {logic [2:0] op; logic [31:0] a, b, exp; bit fast;} vec_t;
  vec_t vt [14] = '{
    '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
    '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 1'b0},
    '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
    '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
    '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0},
    '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0},
    '{3'd5, 32'd100,        32'd7,        32'd14,       1'b0},
    '{3'd7, 32'd100,        32'd7,        32'd2,        1'b0},
    '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1},
    '{3'd6, 32'd5,          32'd0,        32'd5,        1'b1},
    '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1},
    '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1'b1},
    '{3'd4, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 1'b1},
    '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1'b1}
  };

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    logic ov;
    sa = a;
    sb = b;
    ov = a == 32'h80000000 && b == 32'hFFFFFFFF;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFFFFFF : ov ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : ov ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat_exp, input bit poke);
    int lat;
    @(posedge clk); #1;
    op_i = op; op1_i = a; op2_i = b; rd_i = rd; start[d] = 1'b1;
    #1 chk($sformatf("u%0d_busy_start op%0d", d, op), busy[d], 1);
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      start[d] = poke && lat == 4;
      if (lat == 1) chk($sformatf("u%0d_busy_prep", d), busy[d], 1);
      if (done[d] === 1'b1 || lat > 60) break;
    end
    start[d] = 1'b0;
    chk($sformatf("u%0d_lat op%0d", d, op), lat, lat_exp);
    chk($sformatf("u%0d_data op%0d a=%h b=%h", d, op, a, b), rdat[d], exp);
    chk($sformatf("u%0d_addr op%0d", d, op), ra[d], rd);
    chk($sformatf("u%0d_wen op%0d", d, op), wen[d], 1);
    chk($sformatf("u%0d_busy_fix", d), busy[d], 0);
    @(posedge clk); #1;
    chk($sformatf("u%0d_done_clr", d), done[d], 0);
    chk($sformatf("u%0d_hold op%0d", d, op), rdat[d], exp);
  endtask

  task automatic flush_mid(input int d, input int n);
    logic [31:0] pd;
    logic [4:0] pa;
    bit seen;
    pd = rdat[d];
    pa = ra[d];
    seen = 0;
    @(posedge clk); #1;
    op_i = 3'd0; op1_i = 32'd7; op2_i = 32'hFFFFFFFD; rd_i = 5'd9; start[d] = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      start[d] = 1'b0;
      if (wen[d]) seen = 1;
    end
    flush_i = 1'b1;
    #1 if (wen[d]) seen = 1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk($sformatf("u%0d_flush_busy", d), busy[d], 0);
    chk($sformatf("u%0d_flush_data", d), rdat[d], pd);
    chk($sformatf("u%0d_flush_addr", d), ra[d], pa);
    repeat (40) begin
      @(posedge clk); #1;
      if (wen[d]) seen = 1;
    end
    chk($sformatf("u%0d_flush_nowen", d), seen, 0);
    run(d, 3'd4, 32'd9, 32'd3, 5'd5, 32'd3, d ? 10 : 34, 0);
  endtask

  task automatic flush_fix(input int d);
    logic [31:0] pd;
    pd = rdat[d];
    @(posedge clk); #1;
    op_i = 3'd5; op1_i = 32'd5; op2_i = 32'd0; rd_i = 5'd3; start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    #1 chk($sformatf("u%0d_fixflush_wen", d), wen[d], 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk($sformatf("u%0d_fixflush_data", d), rdat[d], pd);
    chk($sformatf("u%0d_fixflush_busy", d), busy[d], 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    bit fst;
    rst = 1'b0; flush_i = 1'b0; op_i = '0; op1_i = '0; op2_i = '0; rd_i = '0;
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d_rst_busy", d), busy[d], 0);
      chk($sformatf("u%0d_rst_done", d), done[d], 0);
      chk($sformatf("u%0d_rst_wen", d), wen[d], 0);
      chk($sformatf("u%0d_rst_data", d), rdat[d], 0);
      chk($sformatf("u%0d_rst_addr", d), ra[d], 0);
    end
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      foreach (vt[i])
        run(d, vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), vt[i].exp, vt[i].fast ? 2 : (d ? 10 : 34), i == 0);
    flush_mid(0, 10);
    flush_mid(1, 5);
    flush_fix(0);
    flush_fix(1);
    for (int k = 0; k < 150; k++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      fst = op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
      for (int d = 0; d < 2; d++)
        run(d, op, a, b, 5'($urandom_range(0, 31)), ref_md(op, a, b), fst ? 2 : (d ? 10 : 34), 0);
    end
    @(posedge clk); #1;
    op_i = 3'd0; op1_i = 32'd3; op2_i = 32'd3; rd_i = 5'd7; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("u0_arst_busy", busy[0], 0);
    chk("u0_arst_data", rdat[0], 0);
    chk("u0_arst_addr", ra[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    fst = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wen[0]) fst = 1;
    end
    chk("u0_arst_nowen", fst, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
